serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor slice plus a borrow
// flop processes minuend - subtrahend LSB first, one bit per clock, behind start/busy/done.
module serial_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] difference,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   r_q, r_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_sign_q, a_sign_d;
  logic           b_sign_q, b_sign_d;
  logic [N-1:0]   difference_q, difference_d;
  logic           borrow_out_q, borrow_out_d;
  logic           overflow_q, overflow_d;

  logic           accept;
  logic           last_bit;
  logic           bit_d;
  logic           br_next;

  // Operands are only sampled outside RUN, so a start during RUN is ignored.
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (cnt_q == CW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Full-subtractor slice on the current operand LSBs and the registered borrow.
  always_comb begin
    bit_d   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  end

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    r_d          = r_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    a_sign_d     = a_sign_q;
    b_sign_d     = b_sign_q;
    difference_d = difference_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    if (accept) begin
      a_d      = minuend;
      b_d      = subtrahend;
      r_d      = '0;
      br_d     = 1'b0;
      cnt_d    = '0;
      a_sign_d = minuend[N-1];
      b_sign_d = subtrahend[N-1];
    end else if (state_q == S_RUN) begin
      a_d        = a_q >> 1;
      b_d        = b_q >> 1;
      r_d        = r_q >> 1;
      r_d[N-1]   = bit_d;
      br_d       = br_next;
      cnt_d      = cnt_q + CW'(1);
      // Final bit: publish the result, with the last difference bit as the sign.
      if (last_bit) begin
        difference_d = r_d;
        borrow_out_d = br_next;
        overflow_d   = (a_sign_q != b_sign_q) && (bit_d != a_sign_q);
      end
    end
  end

  // NOTE: the operand and result shift registers are plain flops, not a memory
  // array, so they take the async reset like every other state bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      a_sign_q     <= 1'b0;
      b_sign_q     <= 1'b0;
      difference_q <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      r_q          <= r_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      a_sign_q     <= a_sign_d;
      b_sign_q     <= b_sign_d;
      difference_q <= difference_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign difference = difference_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at N=1, 8 and 32: results, handshake timing,
// ignored start, back-to-back, async reset, plus a short random sweep against A - B.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start1, a1, b1, busy1, done1, d1, bo1, ov1;
  logic        start8, busy8, done8, bo8, ov8;
  logic [7:0]  a8, b8, d8;
  logic        start32, busy32, done32, bo32, ov32;
  logic [31:0] a32, b32, d32;

  serial_subtractor #(.N(1)) u_n1 (
    .clk(clk), .reset(reset), .start(start1), .minuend(a1), .subtrahend(b1),
    .busy(busy1), .done(done1), .difference(d1), .borrow_out(bo1), .overflow(ov1)
  );

  serial_subtractor #(.N(8)) u_n8 (
    .clk(clk), .reset(reset), .start(start8), .minuend(a8), .subtrahend(b8),
    .busy(busy8), .done(done8), .difference(d8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.N(32)) u_n32 (
    .clk(clk), .reset(reset), .start(start32), .minuend(a32), .subtrahend(b32),
    .busy(busy32), .done(done32), .difference(d32), .borrow_out(bo32), .overflow(ov32)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic overlap_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    case (w)
      1:       begin start1  = s; a1  = a[0];   b1  = b[0];   end
      8:       begin start8  = s; a8  = a[7:0]; b8  = b[7:0]; end
      default: begin start32 = s; a32 = a;      b32 = b;      end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy32;
    endcase
  endfunction

  function automatic logic [31:0] get_diff(input int w);
    case (w)
      1:       return {31'd0, d1};
      8:       return {24'd0, d8};
      default: return d32;
    endcase
  endfunction

  function automatic logic get_bo(input int w);
    case (w)
      1:       return bo1;
      8:       return bo8;
      default: return bo32;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      1:       return ov1;
      8:       return ov8;
      default: return ov32;
    endcase
  endfunction

  // Reference: integer subtraction, unsigned compare, signed range test.
  task automatic ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] diff, output logic bo, output logic ov);
    longint mask, ua, ub, sa, sb, sd, hi, lo;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = ((ua >> (w - 1)) & 1) != 0 ? ua - (longint'(1) << w) : ua;
    sb   = ((ub >> (w - 1)) & 1) != 0 ? ub - (longint'(1) << w) : ub;
    sd   = sa - sb;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    diff = 32'((ua - ub) & mask);
    bo   = (ua < ub);
    ov   = (sd > hi) || (sd < lo);
  endtask

  // Counts edges after the accepting edge until done is seen; -1 if the bound expires.
  task automatic wait_done(input int w, input int max_edges, output int lat);
    lat = -1;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_busy(w) && get_done(w)) overlap_seen = 1'b1;
      if (get_done(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          lat;
    logic [31:0] e_diff;
    logic        e_bo, e_ov;
    ref_sub(w, a, b, e_diff, e_bo, e_ov);
    @(negedge clk);
    set_in(w, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, '0, '0);
    check({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
    wait_done(w, w + 4, lat);
    check({tag, "_latency"}, 32'(lat), 32'(w));
    check({tag, "_diff"}, get_diff(w), e_diff);
    check({tag, "_borrow"}, 32'(get_bo(w)), 32'(e_bo));
    check({tag, "_ovf"}, 32'(get_ov(w)), 32'(e_ov));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(get_done(w)), 32'd0);
  endtask

  initial begin
    int   lat;
    logic early_done;

    reset = 1'b1;
    set_in(1, 1'b0, '0, '0);
    set_in(8, 1'b0, '0, '0);
    set_in(32, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(d8), 32'd0);
    check("rst_borrow", 32'(bo8), 32'd0);
    check("rst_ovf", 32'(ov8), 32'd0);

    run_op(8, 32'h05, 32'h03, "n8_05_03");
    run_op(8, 32'h00, 32'h01, "n8_00_01");
    run_op(8, 32'h80, 32'h01, "n8_80_01");
    run_op(8, 32'h7F, 32'hFF, "n8_7f_ff");

    // start re-pulsed at E3 must be ignored; start held into DONE is accepted at E9.
    early_done = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (done8) early_done = 1'b1;
    end
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    if (done8) early_done = 1'b1;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (done8) early_done = 1'b1;
    end
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h30;
    @(posedge clk);
    @(negedge clk);
    check("ign_no_early_done", 32'(early_done), 32'd0);
    check("ign_done_e8", 32'(done8), 32'd1);
    check("ign_busy_in_done", 32'(busy8), 32'd0);
    check("ign_diff", 32'(d8), 32'h0F);
    check("ign_borrow", 32'(bo8), 32'd0);
    check("ign_ovf", 32'(ov8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    check("b2b_busy", 32'(busy8), 32'd1);
    check("b2b_done_low", 32'(done8), 32'd0);
    wait_done(8, 12, lat);
    check("b2b_latency", 32'(lat), 32'd8);
    check("b2b_diff", 32'(d8), 32'hF0);
    check("b2b_borrow", 32'(bo8), 32'd1);
    check("b2b_ovf", 32'(ov8), 32'd0);

    // Async reset between E4 and E5 of an operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_diff", 32'(d8), 32'd0);
    check("arst_borrow", 32'(bo8), 32'd0);
    check("arst_ovf", 32'(ov8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    early_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) early_done = 1'b1;
    end
    check("arst_no_done", 32'(early_done), 32'd0);
    run_op(8, 32'h33, 32'h11, "n8_after_rst");

    // N = 1: every operand pair, then a few random ones.
    run_op(1, 32'd0, 32'd0, "n1_0_0");
    run_op(1, 32'd0, 32'd1, "n1_0_1");
    run_op(1, 32'd1, 32'd0, "n1_1_0");
    run_op(1, 32'd1, 32'd1, "n1_1_1");
    for (int i = 0; i < 20; i++) run_op(1, $urandom, $urandom, "n1_rand");

    // N = 32 boundaries and random pairs.
    run_op(32, 32'h8000_0000, 32'h0000_0001, "n32_min_1");
    run_op(32, 32'h0000_0000, 32'h0000_0001, "n32_0_1");
    run_op(32, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "n32_max_m1");
    run_op(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "n32_eq");
    for (int i = 0; i < 100; i++) run_op(32, $urandom, $urandom, "n32_rand");

    check("busy_done_exclusive", 32'(overlap_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
